// File: rtl/seq_alu_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_cmd_queue
// Description : FIFO command buffer and one-per-cycle issuer for the
//               sequential ALU (valid/ready in, registered en/opcode/A/B out).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_cmd_queue #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_opcode,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic                     hold,
    input  logic                     flush,
    output logic                     en,
    output logic [1:0]               opcode,
    output logic [DATA_W-1:0]        A,
    output logic [DATA_W-1:0]        B,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         issued
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               ENTRY_W  = 2 + 2 * DATA_W;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic               push;
    logic               pop;

    // A full queue refuses input even if it pops this cycle: no pass-through.
    assign in_ready = (count != FULL_CNT) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && !hold && !flush;

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wptr] <= {in_opcode, in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en     <= 1'b0;
            opcode <= 2'b00;
            A      <= '0;
            B      <= '0;
            count  <= '0;
            issued <= '0;
            wptr   <= '0;
            rptr   <= '0;
        end else begin
            en <= pop;
            // Outputs keep the last issued command while idle.
            if (pop) begin
                {opcode, A, B} <= mem[rptr];
                rptr           <= rptr + 1'b1;
                issued         <= issued + 1'b1;
            end
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
